// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults, FSM state type and output-size helper for the convolution window reader
package conv_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int IN_H_DEF = 227;
  localparam int IN_W_DEF = 227;
  localparam int K_DEF = 11;
  localparam int STRIDE_DEF = 4;
  localparam int PAD_DEF = 0;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  function automatic int out_dim(input int in_sz, input int k, input int stride, input int pad);
    return (in_sz + 2 * pad - k) / stride + 1;
  endfunction
endpackage

// File: rtl/conv_skid_buf.sv
// conv_skid_buf: two-entry valid/ready buffer; the head register drives the outputs so they hold while stalled
module conv_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] e0_q, e1_q, e0_d, e1_d;
  logic [1:0] cnt_q, cnt_d, held;
  logic pop;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o = e0_q;
  assign count_o = cnt_q;
  assign pop = out_valid_o && out_ready_i;
  always_comb begin
    held = cnt_q - {1'b0, pop};
    cnt_d = held + {1'b0, in_valid_i};
    e0_d = (in_valid_i && held == 2'd0) ? in_data_i : pop ? e1_q : e0_q;
    e1_d = (in_valid_i && held == 2'd1) ? in_data_i : e1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
endmodule

// File: rtl/conv_window_reader.sv
// conv_window_reader: streams K*K convolution windows read from a 1-cycle-latency SRAM.
// Define CONV_ZERO_PAD_EN to enable zero-padded borders of PAD pixels.
module conv_window_reader
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IN_H   = IN_H_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int PAD    = PAD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic [DATA_W-1:0] win_data_o,
  output logic              win_last_o,
  output logic              frame_last_o
);
`ifdef CONV_ZERO_PAD_EN
  localparam int PAD_E = PAD;
`else
  localparam int PAD_E = PAD * 0;
`endif
  localparam int OUT_H = out_dim(IN_H, K, STRIDE, PAD_E);
  localparam int OUT_W = out_dim(IN_W, K, STRIDE, PAD_E);
  localparam int CW = CNT_W;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] OY_STEP = ADDR_W'(STRIDE * IN_W);
  localparam logic [ADDR_W-1:0] PAD_OFF = ADDR_W'(PAD_E * IN_W + PAD_E);
  state_e state_q;
  logic [CW-1:0] kx_q, ky_q, ox_q, oy_q;
  logic [ADDR_W-1:0] oy_base_q, win_base_q, row_q, addr_q, start_addr;
  logic pend_q, pend_last_q, pend_flast_q, pend_zero_q;
  logic kx_end, ky_end, ox_end, oy_end, wlast, flast, pop, issue, in_img;
  logic [1:0] buf_cnt, occ;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W+1:0] buf_out;
  assign kx_end = kx_q == CW'(K - 1);
  assign ky_end = ky_q == CW'(K - 1);
  assign ox_end = ox_q == CW'(OUT_W - 1);
  assign oy_end = oy_q == CW'(OUT_H - 1);
  assign wlast = kx_end && ky_end;
  assign flast = wlast && ox_end && oy_end;
  assign pop = win_valid_o && win_ready_i;
  // a slot freed by this cycle's transfer can be refilled at once, giving 1 beat/cycle
  assign occ = buf_cnt - {1'b0, pop};
  assign issue = state_q == RUN && ({1'b0, occ} + {2'b0, pend_q} < 3'd2);
  assign mem_req_o = issue && in_img;
  assign mem_addr_o = addr_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign start_addr = base_addr_i - PAD_OFF;
  assign push_data = pend_zero_q ? '0 : mem_rdata_i;
  assign {win_data_o, win_last_o, frame_last_o} = buf_out;
`ifdef CONV_ZERO_PAD_EN
  localparam logic [CW-1:0] NPAD = CW'(-PAD);
  localparam logic [CW-1:0] SSTEP = CW'(STRIDE);
  logic [CW-1:0] r_q, c_q, wr_q, wc_q;
  // coordinates wrap below zero, so one unsigned compare per axis covers both borders
  assign in_img = r_q < CW'(IN_H) && c_q < CW'(IN_W);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {r_q, c_q, wr_q, wc_q} <= '0;
    else if (state_q == IDLE && start_i) {r_q, c_q, wr_q, wc_q} <= {4{NPAD}};
    else if (issue) begin
      if (!kx_end) c_q <= c_q + ONE;
      else if (!ky_end) begin
        c_q <= wc_q;
        r_q <= r_q + ONE;
      end else if (!ox_end) begin
        wc_q <= wc_q + SSTEP;
        c_q <= wc_q + SSTEP;
        r_q <= wr_q;
      end else begin
        wr_q <= wr_q + SSTEP;
        r_q <= wr_q + SSTEP;
        {wc_q, c_q} <= {2{NPAD}};
      end
    end
  end
`else
  assign in_img = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {kx_q, ky_q, ox_q, oy_q} <= '0;
      {oy_base_q, win_base_q, row_q, addr_q} <= '0;
      {pend_q, pend_last_q, pend_flast_q, pend_zero_q} <= '0;
    end else begin
      pend_q <= issue;
      pend_last_q <= wlast;
      pend_flast_q <= flast;
      pend_zero_q <= !in_img;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          {kx_q, ky_q, ox_q, oy_q} <= '0;
          {oy_base_q, win_base_q, row_q, addr_q} <= {4{start_addr}};
        end
        RUN: if (issue) begin
          if (flast) state_q <= DRAIN;
          if (!kx_end) begin
            kx_q <= kx_q + ONE;
            addr_q <= addr_q + A_ONE;
          end else if (!ky_end) begin
            kx_q <= '0;
            ky_q <= ky_q + ONE;
            row_q <= row_q + ROW_STEP;
            addr_q <= row_q + ROW_STEP;
          end else if (!ox_end) begin
            {kx_q, ky_q} <= '0;
            ox_q <= ox_q + ONE;
            win_base_q <= win_base_q + WIN_STEP;
            row_q <= win_base_q + WIN_STEP;
            addr_q <= win_base_q + WIN_STEP;
          end else begin
            {kx_q, ky_q, ox_q} <= '0;
            oy_q <= oy_q + ONE;
            oy_base_q <= oy_base_q + OY_STEP;
            {win_base_q, row_q, addr_q} <= {3{oy_base_q + OY_STEP}};
          end
        end
        DRAIN: if (pop && frame_last_o) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  conv_skid_buf #(.W(DATA_W + 2)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid_i(pend_q),
    .in_data_i({push_data, pend_last_q, pend_flast_q}),
    .out_valid_o(win_valid_o),
    .out_ready_i(win_ready_i),
    .out_data_o(buf_out),
    .count_o(buf_cnt)
  );
endmodule

// File: tb/tb_conv_window_reader.sv
// tb_conv_window_reader: table-driven and randomized self-checking bench for conv_window_reader
module tb_conv_window_reader;
  localparam int DW = 16, AW = 16, IH = 15, IW = 227, K = 11, S = 4;
  localparam int OW = (IW - K) / S + 1, OH = (IH - K) / S + 1, KK = K * K, TOTAL = OH * OW * KK;
  typedef struct { int idx; logic [15:0] data; logic wl; logic fl; } vec_t;
  logic clk = 0, rst_n = 0, start_i = 0, win_ready = 0;
  logic busy_o, done_o, mem_req_o, win_valid_o, win_last_o, frame_last_o;
  logic [AW-1:0] base_addr = 0, mem_addr_o;
  logic [DW-1:0] mem_rdata = 0, win_data_o;
  int vectors = 0, miscompares = 0, cyc = 0, beat = 0, issued = 0;
  int first_cyc = 0, last_cyc = 0, done_cnt = 0, ready_mode = 1;
  logic busy_prev = 0, stall_prev = 0;
  logic [17:0] prev_beat = 0;
  logic [15:0] base_m = 0;
  logic [17:0] cap [TOTAL];
  vec_t tbl [7];

  conv_window_reader #(.DATA_W(DW), .ADDR_W(AW), .IN_H(IH), .IN_W(IW), .K(K), .STRIDE(S), .PAD(0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata), .win_valid_o(win_valid_o), .win_ready_i(win_ready),
    .win_data_o(win_data_o), .win_last_o(win_last_o), .frame_last_o(frame_last_o)
  );

  always #5 clk = ~clk;
  // SRAM whose word at address a holds a; non-requested cycles return noise
  always @(posedge clk) mem_rdata <= mem_req_o ? mem_addr_o : 16'($urandom);

  function automatic logic [15:0] exp_addr(input logic [15:0] b, input int n);
    int kx = n % K, ky = (n / K) % K, w = n / KK;
    return b + 16'((w / OW * S + ky) * IW + (w % OW) * S + kx);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({busy_o, done_o, mem_req_o, mem_addr_o, win_valid_o, win_data_o, win_last_o, frame_last_o}), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1 win_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode[0];
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      beat = 0;
      issued = 0;
      busy_prev = 0;
      stall_prev = 0;
    end else begin
      if (busy_o && !busy_prev) begin
        beat = 0;
        issued = 0;
        base_m = base_addr;
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(win_valid_o), 64'd1);
        chk("hold_beat", 64'({win_data_o, win_last_o, frame_last_o}), 64'(prev_beat));
      end
      if (win_valid_o && win_ready) begin
        if (beat == 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("beat", 64'({win_data_o, win_last_o, frame_last_o}),
            64'({exp_addr(base_m, beat), beat % KK == KK - 1, beat == TOTAL - 1}));
        if (beat < TOTAL) cap[beat] = {win_data_o, win_last_o, frame_last_o};
        beat++;
      end
      if (mem_req_o) begin
        chk("req_addr", 64'(mem_addr_o), 64'(exp_addr(base_m, issued)));
        issued++;
        chk("outstanding_le2", 64'(issued - beat <= 2), 64'd1);
      end
      if (done_o) done_cnt++;
      stall_prev = win_valid_o && !win_ready;
      prev_beat = {win_data_o, win_last_o, frame_last_o};
      busy_prev = busy_o;
    end
  endtask

  task automatic run_frame(input int budget, input bit poke);
    int d0 = done_cnt;
    for (int i = 0; i < budget && !done_o; i++) begin
      start_i = poke && (i % 1000 == 500);
      tick();
    end
    start_i = 0;
    chk("done_seen", 64'(done_o), 64'd1);
    chk("frame_beats", 64'(beat), 64'(TOTAL));
    tick();
    chk("busy_after_done", 64'({busy_o, done_o}), 64'd0);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    tbl[0] = '{0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{10, 16'h010A, 1'b0, 1'b0};
    tbl[2] = '{11, 16'h01E3, 1'b0, 1'b0};
    tbl[3] = '{120, 16'h09E8, 1'b1, 1'b0};
    tbl[4] = '{121, 16'h0104, 1'b0, 1'b0};
    tbl[5] = '{6655, 16'h048C, 1'b0, 1'b0};
    tbl[6] = '{13309, 16'h0E4C, 1'b1, 1'b1};
    repeat (3) tick();
    chk_zero("reset_state");
    rst_n = 1;
    repeat (3) tick();
    #2 rst_n = 0;
    #1 chk_zero("reset_idle");
    tick();
    rst_n = 1;
    tick();
    // frame 1: ready held high, latency, throughput and table of known beats
    base_addr = 16'h0100;
    start_i = 1;
    tick();
    start_i = 0;
    chk("lat_req_T1", 64'({busy_o, mem_req_o, win_valid_o}), 64'b110);
    run_frame(20000, 0);
    chk("f1_span", 64'(last_cyc - first_cyc + 1), 64'(TOTAL));
    for (int i = 0; i < 7; i++)
      chk($sformatf("tbl_beat%0d", tbl[i].idx), 64'(cap[tbl[i].idx]), 64'({tbl[i].data, tbl[i].wl, tbl[i].fl}));
    // frame 2: random backpressure, base near top of the address space so it wraps
    base_addr = 16'hFF00 + 16'($urandom_range(0, 255));
    ready_mode = 2;
    start_i = 1;
    tick();
    start_i = 0;
    run_frame(40000, 0);
    // frame 3: base 0, stray starts with a different base while busy
    base_addr = 16'h0000;
    ready_mode = 1;
    start_i = 1;
    tick();
    start_i = 0;
    base_addr = 16'hBEEF;
    run_frame(20000, 1);
    chk("final_beat", 64'(cap[TOTAL - 1]), 64'({16'd3404, 1'b1, 1'b1}));
    // reset mid-frame, then restart from window 0
    base_addr = 16'h2000;
    ready_mode = 2;
    start_i = 1;
    tick();
    start_i = 0;
    repeat (300) tick();
    #2 rst_n = 0;
    #1 chk_zero("reset_mid_frame");
    repeat (2) tick();
    rst_n = 1;
    tick();
    base_addr = 16'h3000;
    ready_mode = 1;
    start_i = 1;
    tick();
    start_i = 0;
    repeat (40) tick();
    chk("restart_beat0", 64'(cap[0]), 64'({16'h3000, 2'b00}));
    chk("restart_progress", 64'(beat >= 30), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
